// File: rtl/harness_pkg.sv
// Shared types and constants for the start/done program harness: FSM states,
// fixed data-memory addresses, and the load/read address sequences.
package harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    READ,
    RESP
  } state_t;

  // Fixed program addresses; multi-byte fields are big-endian (MSB first).
  localparam logic [7:0] ADR_DIVA_NUM = 8'd0;
  localparam logic [7:0] ADR_DIVA_DEN = 8'd2;
  localparam logic [7:0] ADR_QA       = 8'd4;
  localparam logic [7:0] ADR_DIVB_NUM = 8'd7;
  localparam logic [7:0] ADR_DIVB_DEN = 8'd8;
  localparam logic [7:0] ADR_QB       = 8'd10;
  localparam logic [7:0] ADR_SQRT_IN  = 8'd13;
  localparam logic [7:0] ADR_ROOT     = 8'd15;

  localparam int LOAD_LEN = 8;
  localparam int READ_LEN = 6;

  // Byte order of the operand writes; load_byte() must follow the same order.
  localparam logic [7:0] LOAD_ADR [LOAD_LEN] = '{
    ADR_DIVA_NUM, ADR_DIVA_NUM + 8'd1, ADR_DIVA_DEN, ADR_DIVB_NUM,
    ADR_DIVB_DEN, ADR_DIVB_DEN + 8'd1, ADR_SQRT_IN, ADR_SQRT_IN + 8'd1
  };

  // Byte order of the result reads: quot_a[23:0], quot_b[15:0], root.
  localparam logic [7:0] READ_ADR [READ_LEN] = '{
    ADR_QA, ADR_QA + 8'd1, ADR_QA + 8'd2, ADR_QB, ADR_QB + 8'd1, ADR_ROOT
  };

  typedef struct packed {
    logic [15:0] a_num;
    logic [7:0]  a_den;
    logic [7:0]  b_num;
    logic [15:0] b_den;
    logic [15:0] sqrt_in;
  } operands_t;

  // Operand byte written at step idx of the load sequence.
  function automatic logic [7:0] load_byte(input operands_t ops, input logic [2:0] idx);
    case (idx)
      3'd0:    load_byte = ops.a_num[15:8];
      3'd1:    load_byte = ops.a_num[7:0];
      3'd2:    load_byte = ops.a_den;
      3'd3:    load_byte = ops.b_num;
      3'd4:    load_byte = ops.b_den[15:8];
      3'd5:    load_byte = ops.b_den[7:0];
      3'd6:    load_byte = ops.sqrt_in[15:8];
      default: load_byte = ops.sqrt_in[7:0];
    endcase
  endfunction

endpackage

// File: rtl/harness_timer.sv
// Run-length counter: 16-bit, saturating at 0xFFFF, with synchronous clear
// and a timeout hit flag raised on the edge at which the count reaches TIMEOUT.
module harness_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [15:0] o_cnt,
  output logic        o_hit
);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  // Compare the value being loaded so the run stops with cycles == TIMEOUT.
  assign o_hit     = i_en && (w_cnt_inc == 16'(TIMEOUT));
  assign o_cnt     = r_cnt;

  // Count run cycles; clear wins over enable.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (i_clr) begin
      r_cnt <= 16'd0;
    end else if (i_en) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/dut_harness.sv
// Start/done program initiator: loads one operand set into data memory, pulses
// start, waits for done or timeout, reads the results back and offers them on
// a valid/ready port. Memory-port outputs are decoded from state so a reset
// drops start and WrMem immediately.
module dut_harness
  import harness_pkg::*;
#(
  parameter int AW        = 8,
  parameter int TIMEOUT   = 1024,
  parameter int START_CYC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [15:0]   div_a_num,
  input  logic [7:0]    div_a_den,
  input  logic [7:0]    div_b_num,
  input  logic [15:0]   div_b_den,
  input  logic [15:0]   sqrt_in,
  output logic          start,
  input  logic          done,
  output logic [AW-1:0] MemAdr,
  output logic          WrMem,
  output logic [7:0]    toMem,
  input  logic [7:0]    fmMem,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [23:0]   quot_a,
  output logic [15:0]   quot_b,
  output logic [7:0]    root,
  output logic [15:0]   cycles,
  output logic          timeout
);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_next;
  operands_t   r_ops;
  logic [23:0] r_quot_a;
  logic [15:0] r_quot_b;
  logic [7:0]  r_root;
  logic        r_timeout;
  logic        w_tmr_clr;
  logic        w_tmr_en;
  logic        w_tmr_hit;
  logic [15:0] w_cycles;
  logic        w_done_ok;
  logic        w_accept;

  harness_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_cnt (w_cycles),
    .o_hit (w_tmr_hit)
  );

  // A count of zero marks the first RUN cycle, where a stale done is ignored.
  assign w_done_ok = done && (w_cycles != 16'd0);
  assign w_accept  = cmd_valid && cmd_ready;

  // Next-state, step index and all protocol outputs.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    cmd_ready    = 1'b0;
    start        = 1'b0;
    WrMem        = 1'b0;
    MemAdr       = '0;
    toMem        = 8'd0;
    res_valid    = 1'b0;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_next = LOAD;
          w_idx_next   = 4'd0;
        end
      end
      LOAD: begin
        WrMem  = 1'b1;
        MemAdr = AW'(LOAD_ADR[r_idx[2:0]]);
        toMem  = load_byte(r_ops, r_idx[2:0]);
        if (r_idx == 4'(LOAD_LEN - 1)) begin
          w_state_next = START;
          w_idx_next   = 4'd0;
        end else begin
          w_idx_next = r_idx + 4'd1;
        end
      end
      START: begin
        start = 1'b1;
        if (r_idx == 4'(START_CYC - 1)) begin
          w_tmr_clr    = 1'b1;
          w_state_next = RUN;
          w_idx_next   = 4'd0;
        end else begin
          w_idx_next = r_idx + 4'd1;
        end
      end
      RUN: begin
        w_tmr_en = 1'b1;
        if (w_done_ok || w_tmr_hit) begin
          w_state_next = READ;
          w_idx_next   = 4'd0;
        end
      end
      READ: begin
        MemAdr = AW'(READ_ADR[r_idx[2:0]]);
        if (r_idx == 4'(READ_LEN - 1)) begin
          w_state_next = RESP;
          w_idx_next   = 4'd0;
        end else begin
          w_idx_next = r_idx + 4'd1;
        end
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = 4'd0;
      end
    endcase
  end

  // State and step-index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Operand latch on command handshake; held through LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ops <= '0;
    end else if (w_accept) begin
      r_ops <= '{a_num: div_a_num, a_den: div_a_den, b_num: div_b_num,
                 b_den: div_b_den, sqrt_in: sqrt_in};
    end
  end

  // Timeout flag and result capture from the combinational memory read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
      r_quot_a  <= 24'd0;
      r_quot_b  <= 16'd0;
      r_root    <= 8'd0;
    end else begin
      if (w_accept) begin
        r_timeout <= 1'b0;
      end else if (r_state == RUN && w_tmr_hit && !w_done_ok) begin
        r_timeout <= 1'b1;
      end
      if (r_state == READ) begin
        case (r_idx[2:0])
          3'd0:    r_quot_a[23:16] <= fmMem;
          3'd1:    r_quot_a[15:8]  <= fmMem;
          3'd2:    r_quot_a[7:0]   <= fmMem;
          3'd3:    r_quot_b[15:8]  <= fmMem;
          3'd4:    r_quot_b[7:0]   <= fmMem;
          3'd5:    r_root          <= fmMem;
          default: ;
        endcase
      end
    end
  end

  assign quot_a  = r_quot_a;
  assign quot_b  = r_quot_b;
  assign root    = r_root;
  assign cycles  = w_cycles;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_dut_harness.sv
// Bench for dut_harness: instance A (TIMEOUT=1024) runs against a behavioural
// core model that answers 33 clocks after start; instance B (TIMEOUT=20) has
// done tied low and a preloaded result area, so it always times out.
module tb_dut_harness;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_ready;
  logic [15:0] div_a_num;
  logic [7:0]  div_a_den;
  logic [7:0]  div_b_num;
  logic [15:0] div_b_den;
  logic [15:0] sqrt_in;

  logic        cmd_valid_a, cmd_ready_a, start_a, done_a, wr_a, res_valid_a, timeout_a;
  logic [7:0]  adr_a, to_a, fm_a, root_a;
  logic [23:0] quot_a_a;
  logic [15:0] quot_b_a, cycles_a;

  logic        cmd_valid_b, cmd_ready_b, start_b, done_b, wr_b, res_valid_b, timeout_b;
  logic [7:0]  adr_b, to_b, fm_b, root_b;
  logic [23:0] quot_a_b;
  logic [15:0] quot_b_b, cycles_b;

  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  logic        core_busy;
  logic        core_done;
  int          core_cnt;
  logic        force_done;

  logic [7:0]  wq_adr [$];
  logic [7:0]  wq_dat [$];
  logic [7:0]  exp_adr [8] = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9, 8'd13, 8'd14};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dut_harness #(.AW(8), .TIMEOUT(1024), .START_CYC(1)) u_dut_a (
    .clk       (clk),        .reset     (reset),
    .cmd_valid (cmd_valid_a), .cmd_ready (cmd_ready_a),
    .div_a_num (div_a_num),  .div_a_den (div_a_den),
    .div_b_num (div_b_num),  .div_b_den (div_b_den),
    .sqrt_in   (sqrt_in),    .start     (start_a),
    .done      (done_a),     .MemAdr    (adr_a),
    .WrMem     (wr_a),       .toMem     (to_a),
    .fmMem     (fm_a),       .res_valid (res_valid_a),
    .res_ready (res_ready),  .quot_a    (quot_a_a),
    .quot_b    (quot_b_a),   .root      (root_a),
    .cycles    (cycles_a),   .timeout   (timeout_a)
  );

  dut_harness #(.AW(8), .TIMEOUT(20), .START_CYC(1)) u_dut_b (
    .clk       (clk),        .reset     (reset),
    .cmd_valid (cmd_valid_b), .cmd_ready (cmd_ready_b),
    .div_a_num (div_a_num),  .div_a_den (div_a_den),
    .div_b_num (div_b_num),  .div_b_den (div_b_den),
    .sqrt_in   (sqrt_in),    .start     (start_b),
    .done      (done_b),     .MemAdr    (adr_b),
    .WrMem     (wr_b),       .toMem     (to_b),
    .fmMem     (fm_b),       .res_valid (res_valid_b),
    .res_ready (res_ready),  .quot_a    (quot_a_b),
    .quot_b    (quot_b_b),   .root      (root_b),
    .cycles    (cycles_b),   .timeout   (timeout_b)
  );

  function automatic logic [7:0] isqrt16(input logic [15:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 8'(r);
  endfunction

  assign fm_a   = mem_a[adr_a[3:0]];
  assign fm_b   = mem_b[adr_b[3:0]];
  assign done_a = core_done | force_done;
  assign done_b = 1'b0;

  // Memory A plus behavioural core model: done pulses 33 clocks after the start edge.
  always @(posedge clk) begin
    logic [15:0] a_num, b_den, sq;
    logic [23:0] qa;
    logic [15:0] qb;
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 8'h00;
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else begin
      if (wr_a) mem_a[adr_a[3:0]] <= to_a;
      core_done <= 1'b0;
      if (start_a && !force_done) begin
        core_busy <= 1'b1;
        core_cnt  <= 0;
      end else if (core_busy) begin
        if (core_cnt == 31) begin
          a_num = {mem_a[0], mem_a[1]};
          b_den = {mem_a[8], mem_a[9]};
          sq    = {mem_a[13], mem_a[14]};
          qa    = (mem_a[2] == 8'd0) ? 24'hFFFFFF : 24'(a_num / 16'(mem_a[2]));
          qb    = (b_den == 16'd0) ? 16'hFFFF : 16'(16'(mem_a[7]) / b_den);
          mem_a[4]  <= qa[23:16];
          mem_a[5]  <= qa[15:8];
          mem_a[6]  <= qa[7:0];
          mem_a[10] <= qb[15:8];
          mem_a[11] <= qb[7:0];
          mem_a[15] <= isqrt16(sq);
          core_busy <= 1'b0;
          core_done <= 1'b1;
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end
  end

  // Memory B: result area preloaded with 0xA0+address, no core behind it.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= 8'(8'hA0 + i);
    end else if (wr_b) begin
      mem_b[adr_b[3:0]] <= to_b;
    end
  end

  // Record instance A memory writes.
  always @(negedge clk) begin
    if (!reset && wr_a) begin
      wq_adr.push_back(adr_a);
      wq_dat.push_back(to_a);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] an, input logic [7:0] ad, input logic [7:0] bn,
                         input logic [15:0] bd, input logic [15:0] sq);
    div_a_num = an;
    div_a_den = ad;
    div_b_num = bn;
    div_b_den = bd;
    sqrt_in   = sq;
  endtask

  // Offer one command to the selected instance for a single cycle.
  task automatic send(input bit sel);
    @(negedge clk);
    if (sel) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
  endtask

  task automatic wait_res(input bit sel, input int budget);
    int k = 0;
    while (!(sel ? res_valid_b : res_valid_a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(sel ? "res_valid_b" : "res_valid_a", sel ? res_valid_b : res_valid_a, 1);
  endtask

  task automatic check_writes(input logic [63:0] exp_dat);
    check("wr_count", wq_adr.size(), 8);
    for (int i = 0; i < 8 && i < wq_adr.size(); i++) begin
      check($sformatf("wr_adr%0d", i), wq_adr[i], exp_adr[i]);
      check($sformatf("wr_dat%0d", i), wq_dat[i], exp_dat[63 - 8*i -: 8]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    res_ready   = 1'b1;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    force_done  = 1'b0;
    set_ops(16'h0, 8'h0, 8'h0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_cmd_ready", cmd_ready_a, 1);
    check("rst_start",     start_a,     0);
    check("rst_wrmem",     wr_a,        0);
    check("rst_memadr",    adr_a,       0);
    check("rst_tomem",     to_a,        0);
    check("rst_res_valid", res_valid_a, 0);
    check("rst_quot_a",    quot_a_a,    0);
    check("rst_cycles",    cycles_a,    0);
    check("rst_timeout",   timeout_a,   0);
    reset = 1'b0;

    // Reset asserted mid-LOAD, after three writes
    set_ops(16'h1234, 8'h00, 8'h56, 16'h0000, 16'h0000);
    send(0);
    repeat (3) @(negedge clk);
    check("midload_wr_before", wr_a, 1);
    #1 reset = 1'b1;
    #1;
    check("midload_wr",        wr_a,        0);
    check("midload_start",     start_a,     0);
    check("midload_memadr",    adr_a,       0);
    check("midload_tomem",     to_a,        0);
    check("midload_res_valid", res_valid_a, 0);
    check("midload_quot_b",    quot_b_a,    0);
    check("midload_cycles",    cycles_a,    0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midload_cmd_ready", cmd_ready_a, 1);
    wq_adr.delete();
    wq_dat.delete();

    // Zero divisors and zero sqrt operand
    send(0);
    wait_res(0, 200);
    check("z_quot_a",  quot_a_a,  24'hFFFFFF);
    check("z_quot_b",  quot_b_a,  16'hFFFF);
    check("z_root",    root_a,    8'h00);
    check("z_cycles",  cycles_a,  33);
    check("z_timeout", timeout_a, 0);
    check_writes(64'h12_34_00_56_00_00_00_00);
    @(negedge clk);
    check("z_cmd_ready_after", cmd_ready_a, 1);
    wq_adr.delete();
    wq_dat.delete();

    // Ordinary operands: 1000/7=142, 200/9=22, sqrt(400)=20
    set_ops(16'd1000, 8'd7, 8'd200, 16'd9, 16'd400);
    send(0);
    wait_res(0, 200);
    check("n_quot_a",  quot_a_a,  24'h00008E);
    check("n_quot_b",  quot_b_a,  16'h0016);
    check("n_root",    root_a,    8'h14);
    check("n_cycles",  cycles_a,  33);
    check("n_timeout", timeout_a, 0);
    check_writes(64'h03_E8_07_C8_00_09_01_90);
    @(negedge clk);

    // Result held while res_ready is low; commands ignored
    res_ready = 1'b0;
    send(0);
    wait_res(0, 200);
    for (int i = 0; i < 10; i++) begin
      cmd_valid_a = (i % 2 == 0);
      @(negedge clk);
      check($sformatf("hold%0d_res_valid", i), res_valid_a, 1);
      check($sformatf("hold%0d_cmd_ready", i), cmd_ready_a, 0);
      check($sformatf("hold%0d_wrmem", i),     wr_a,        0);
      check($sformatf("hold%0d_quot_a", i),    quot_a_a,    24'h00008E);
      check($sformatf("hold%0d_root", i),      root_a,      8'h14);
    end
    cmd_valid_a = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    check("hold_release_cmd_ready", cmd_ready_a, 1);
    check("hold_release_res_valid", res_valid_a, 0);

    // Timeout on instance B; result bytes still read back
    set_ops(16'h4321, 8'h11, 8'h22, 16'h3344, 16'h5566);
    send(1);
    wait_res(1, 200);
    check("to_timeout", timeout_b, 1);
    check("to_cycles",  cycles_b,  20);
    check("to_quot_a",  quot_a_b,  24'hA4A5A6);
    check("to_quot_b",  quot_b_b,  16'hAAAB);
    check("to_root",    root_b,    8'hAF);
    @(negedge clk);
    check("to_cmd_ready_after", cmd_ready_b, 1);

    // done held high from before start: ignored in the first RUN cycle
    force_done = 1'b1;
    send(0);
    wait_res(0, 200);
    check("fd_cycles",  cycles_a,  2);
    check("fd_timeout", timeout_a, 0);
    force_done = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
